// File: rtl/stage_mem_pkg.sv
// Shared definitions for the MIPS memory stage: datapath width, FSM encodings and a decode helper.
package stage_mem_pkg;

    localparam int WORD = 32;

    localparam logic [0:0] MEM_IDLE = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;

    function automatic logic is_memop(input logic mem_read, input logic mem_write);
        return mem_read | mem_write;
    endfunction

endpackage

// File: rtl/stage_mem_memwb.sv
// MEM/WB pipeline register, falling-edge clocked; a bubble clears every field so writeback is a no-op.
module buffer_memwb
    import stage_mem_pkg::*;
#(
    parameter int DATA_W = WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bubble_in,
    input  logic [DATA_W-1:0] read_data_in,
    input  logic [DATA_W-1:0] result_in,
    input  logic [4:0]        reg_dst_in,
    input  logic              mem_to_reg_in,
    input  logic              reg_write_in,
    output logic [DATA_W-1:0] read_data_out,
    output logic [DATA_W-1:0] result_out,
    output logic [4:0]        reg_dst_out,
    output logic              mem_to_reg_out,
    output logic              reg_write_out
);

    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [4:0]        reg_dst_q, reg_dst_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic              reg_write_q, reg_write_d;

    always_comb begin
        read_data_d  = '0;
        result_d     = '0;
        reg_dst_d    = '0;
        mem_to_reg_d = 1'b0;
        reg_write_d  = 1'b0;
        if (!bubble_in) begin
            read_data_d  = read_data_in;
            result_d     = result_in;
            reg_dst_d    = reg_dst_in;
            mem_to_reg_d = mem_to_reg_in;
            reg_write_d  = reg_write_in;
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            read_data_q  <= '0;
            result_q     <= '0;
            reg_dst_q    <= '0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
        end else begin
            read_data_q  <= read_data_d;
            result_q     <= result_d;
            reg_dst_q    <= reg_dst_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_write_q  <= reg_write_d;
        end
    end

    assign read_data_out  = read_data_q;
    assign result_out     = result_q;
    assign reg_dst_out    = reg_dst_q;
    assign mem_to_reg_out = mem_to_reg_q;
    assign reg_write_out  = reg_write_q;

endmodule

// File: rtl/stage_mem.sv
// MIPS memory stage: req/ack data-memory access with upstream stall and MEM/WB capture.
// Optional access watchdog enabled with `define MEMSTAGE_TIMEOUT_EN.
module stage_mem
    import stage_mem_pkg::*;
#(
    parameter int DATA_W         = WORD,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] Branch_Target_in,
    input  logic [DATA_W-1:0] Result_in,
    input  logic [DATA_W-1:0] MemWriteData_in,
    input  logic [4:0]        RegDstAddress_in,
    input  logic              zero_in,
    input  logic              Branch_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic              MemtoReg_in,
    input  logic              RegWrite_in,
    output logic              PCSrc,
    output logic [DATA_W-1:0] Branch_Target_out,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [DATA_W-1:0] ReadData_out,
    output logic [DATA_W-1:0] Result_out,
    output logic [4:0]        RegDstAddress_out,
    output logic              MemtoReg_out,
    output logic              RegWrite_out,
    output logic              mem_error
);

    logic [0:0]        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              memop;
    logic              in_wait;
    logic              ack_done;
    logic              timeout_hit;
    logic              wb_bubble;
    logic [DATA_W-1:0] wb_read_data;

`ifdef MEMSTAGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Counter sits at zero outside WAIT, so every new access starts a fresh window.
    always_comb begin
        timeout_hit = in_wait & ~dmem_ack & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        cnt_d       = in_wait ? cnt_q + 1'b1 : '0;
        err_d       = err_q | timeout_hit;
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign mem_error = err_q;
`else
    assign timeout_hit = 1'b0;
    assign mem_error   = 1'b0;
`endif

    // An aborted access also releases the stall so upstream retires the failed op instead of reissuing it.
    always_comb begin
        memop        = is_memop(MemRead_in, MemWrite_in);
        in_wait      = (state_q == MEM_WAIT);
        ack_done     = in_wait & dmem_ack;
        stall        = (~in_wait & memop) | (in_wait & ~dmem_ack & ~timeout_hit);
        PCSrc        = Branch_in & zero_in & ~stall;
        wb_bubble    = (~in_wait & memop) | (in_wait & ~dmem_ack);
        wb_read_data = (ack_done & ~MemWrite_in) ? dmem_rdata : '0;
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (!in_wait) begin
            if (memop) begin
                state_d = MEM_WAIT;
                req_d   = 1'b1;
                we_d    = MemWrite_in;
                addr_d  = Result_in;
                wdata_d = MemWriteData_in;
            end
        end else if (dmem_ack || timeout_hit) begin
            state_d = MEM_IDLE;
            req_d   = 1'b0;
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MEM_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign Branch_Target_out = Branch_Target_in;
    assign dmem_req          = req_q;
    assign dmem_we           = we_q;
    assign dmem_addr         = addr_q;
    assign dmem_wdata        = wdata_q;

    buffer_memwb #(
        .DATA_W(DATA_W)
    ) u_memwb (
        .clk            (clk),
        .reset          (reset),
        .bubble_in      (wb_bubble),
        .read_data_in   (wb_read_data),
        .result_in      (Result_in),
        .reg_dst_in     (RegDstAddress_in),
        .mem_to_reg_in  (MemtoReg_in),
        .reg_write_in   (RegWrite_in),
        .read_data_out  (ReadData_out),
        .result_out     (Result_out),
        .reg_dst_out    (RegDstAddress_out),
        .mem_to_reg_out (MemtoReg_out),
        .reg_write_out  (RegWrite_out)
    );

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem: falling-edge pipeline, inputs driven 1 ns after each falling edge.
module tb_stage_mem;

    logic        clk;
    logic        reset;
    logic [31:0] Branch_Target_in, Result_in, MemWriteData_in;
    logic [4:0]  RegDstAddress_in;
    logic        zero_in, Branch_in, MemRead_in, MemWrite_in, MemtoReg_in, RegWrite_in;
    logic        PCSrc, stall, dmem_req, dmem_we, dmem_ack;
    logic [31:0] Branch_Target_out, dmem_addr, dmem_wdata, dmem_rdata;
    logic [31:0] ReadData_out, Result_out;
    logic [4:0]  RegDstAddress_out;
    logic        MemtoReg_out, RegWrite_out, mem_error;

    int total = 0;
    int bad   = 0;
    int req_rises = 0;
    int stall_hi  = 0;
    int snap_req, snap_stall;

    stage_mem #(
        .DATA_W(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .Branch_Target_in  (Branch_Target_in),
        .Result_in         (Result_in),
        .MemWriteData_in   (MemWriteData_in),
        .RegDstAddress_in  (RegDstAddress_in),
        .zero_in           (zero_in),
        .Branch_in         (Branch_in),
        .MemRead_in        (MemRead_in),
        .MemWrite_in       (MemWrite_in),
        .MemtoReg_in       (MemtoReg_in),
        .RegWrite_in       (RegWrite_in),
        .PCSrc             (PCSrc),
        .Branch_Target_out (Branch_Target_out),
        .stall             (stall),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .dmem_rdata        (dmem_rdata),
        .dmem_ack          (dmem_ack),
        .ReadData_out      (ReadData_out),
        .Result_out        (Result_out),
        .RegDstAddress_out (RegDstAddress_out),
        .MemtoReg_out      (MemtoReg_out),
        .RegWrite_out      (RegWrite_out),
        .mem_error         (mem_error)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    always @(posedge dmem_req) req_rises++;

    // The rising edge sits mid-cycle, so it sees the stall value the next falling edge will act on.
    always @(posedge clk) if (stall) stall_hi++;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] res, input logic [31:0] wdata, input logic [4:0] rd,
                                 input logic rd_en, input logic wr_en, input logic m2r, input logic rw);
        Result_in        = res;
        MemWriteData_in  = wdata;
        RegDstAddress_in = rd;
        MemRead_in       = rd_en;
        MemWrite_in      = wr_en;
        MemtoReg_in      = m2r;
        RegWrite_in      = rw;
    endtask

    initial begin
        reset = 1'b0;
        Branch_Target_in = '0; zero_in = 1'b0; Branch_in = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        applyStimulus(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        checkOutput("reset_req", {31'b0, dmem_req}, 32'h0);
        checkOutput("reset_result", Result_out, 32'h0);
        checkOutput("reset_regwrite", {31'b0, RegWrite_out}, 32'h0);
        checkOutput("reset_memerr", {31'b0, mem_error}, 32'h0);
        @(posedge clk);
        reset = 1'b1;
        tick();

        // ALU op, with a stray ack in IDLE that must be ignored
        applyStimulus(32'h0000_0010, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        dmem_ack = 1'b1; dmem_rdata = 32'hAAAA_5555;
        #1 checkOutput("alu_stall_pre", {31'b0, stall}, 32'h0);
        tick();
        dmem_ack = 1'b0;
        checkOutput("alu_result", Result_out, 32'h10);
        checkOutput("alu_regdst", {27'b0, RegDstAddress_out}, 32'd5);
        checkOutput("alu_regwrite", {31'b0, RegWrite_out}, 32'h1);
        checkOutput("alu_readdata", ReadData_out, 32'h0);
        checkOutput("alu_idle_ack_req", {31'b0, dmem_req}, 32'h0);
        checkOutput("alu_stall_post", {31'b0, stall}, 32'h0);

        // Branch without memop
        Branch_in = 1'b1; zero_in = 1'b1; Branch_Target_in = 32'h1000_0200;
        #1;
        checkOutput("br_pcsrc", {31'b0, PCSrc}, 32'h1);
        checkOutput("br_target", Branch_Target_out, 32'h1000_0200);
        zero_in = 1'b0;
        #1 checkOutput("br_notzero", {31'b0, PCSrc}, 32'h0);
        zero_in = 1'b1;

        // Load 0x40, ack raised three edges after the request edge
        snap_req = req_rises; snap_stall = stall_hi;
        applyStimulus(32'h0000_0040, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
        #1 checkOutput("ld_pcsrc_stalled", {31'b0, PCSrc}, 32'h0);
        tick();
        checkOutput("ld_req", {31'b0, dmem_req}, 32'h1);
        checkOutput("ld_we", {31'b0, dmem_we}, 32'h0);
        checkOutput("ld_addr", dmem_addr, 32'h40);
        checkOutput("ld_bubble0", {31'b0, RegWrite_out}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("ld_wait_stall", {31'b0, stall}, 32'h1);
            tick();
            checkOutput("ld_wait_regwrite", {31'b0, RegWrite_out}, 32'h0);
            checkOutput("ld_wait_req", {31'b0, dmem_req}, 32'h1);
        end
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        #1 checkOutput("ld_ack_stall", {31'b0, stall}, 32'h0);
        tick();
        dmem_ack = 1'b0;
        checkOutput("ld_readdata", ReadData_out, 32'hDEAD_BEEF);
        checkOutput("ld_memtoreg", {31'b0, MemtoReg_out}, 32'h1);
        checkOutput("ld_regwrite", {31'b0, RegWrite_out}, 32'h1);
        checkOutput("ld_regdst", {27'b0, RegDstAddress_out}, 32'd7);
        checkOutput("ld_req_done", {31'b0, dmem_req}, 32'h0);
        checkOutput("ld_stall_edges", stall_hi - snap_stall, 32'd4);
        checkOutput("ld_req_pulses", req_rises - snap_req, 32'd1);
        Branch_in = 1'b0; zero_in = 1'b0;

        // Store 0x44, ack one edge after the request edge
        applyStimulus(32'h0000_0044, 32'h1234_5678, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("st_we", {31'b0, dmem_we}, 32'h1);
        checkOutput("st_addr", dmem_addr, 32'h44);
        checkOutput("st_wdata", dmem_wdata, 32'h1234_5678);
        checkOutput("st_stall_wait", {31'b0, stall}, 32'h1);
        tick();
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        #1 checkOutput("st_ack_stall", {31'b0, stall}, 32'h0);
        tick();
        dmem_ack = 1'b0;
        checkOutput("st_regwrite", {31'b0, RegWrite_out}, 32'h0);
        checkOutput("st_readdata", ReadData_out, 32'h0);
        checkOutput("st_req_done", {31'b0, dmem_req}, 32'h0);

        // Read+write together at an unaligned address behaves as a store
        applyStimulus(32'h0000_0047, 32'h0BAD_F00D, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        checkOutput("rw_we", {31'b0, dmem_we}, 32'h1);
        checkOutput("rw_addr", dmem_addr, 32'h47);
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        tick();
        dmem_ack = 1'b0;
        checkOutput("rw_readdata", ReadData_out, 32'h0);
        checkOutput("rw_regwrite", {31'b0, RegWrite_out}, 32'h1);

        // Back-to-back: next load needs one IDLE edge before its request
        applyStimulus(32'h0000_0080, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        checkOutput("b2b_req_gap", {31'b0, dmem_req}, 32'h0);
        checkOutput("b2b_stall_idle", {31'b0, stall}, 32'h1);
        tick();
        checkOutput("b2b_req", {31'b0, dmem_req}, 32'h1);
        checkOutput("b2b_addr", dmem_addr, 32'h80);

        // Asynchronous reset in the middle of WAIT
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_wait_req", {31'b0, dmem_req}, 32'h0);
        checkOutput("rst_wait_addr", dmem_addr, 32'h0);
        checkOutput("rst_wait_result", Result_out, 32'h0);
        checkOutput("rst_wait_regdst", {27'b0, RegDstAddress_out}, 32'h0);
        checkOutput("rst_wait_regwrite", {31'b0, RegWrite_out}, 32'h0);
        @(posedge clk);
        reset = 1'b1;
        dmem_ack = 1'b1;
        #1 checkOutput("rst_state_idle", {31'b0, stall}, 32'h1);
        tick();
        checkOutput("rst_reissue_req", {31'b0, dmem_req}, 32'h1);
        tick();
        dmem_ack = 1'b0;
        checkOutput("rst_reissue_done", {31'b0, dmem_req}, 32'h0);

        // Load that never receives an ack
        applyStimulus(32'h0000_0090, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
`ifdef MEMSTAGE_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            checkOutput("to_stall", {31'b0, stall}, 32'h1);
            tick();
            checkOutput("to_err_pending", {31'b0, mem_error}, 32'h0);
        end
        checkOutput("to_abort_stall", {31'b0, stall}, 32'h0);
        tick();
        checkOutput("to_err", {31'b0, mem_error}, 32'h1);
        checkOutput("to_regwrite", {31'b0, RegWrite_out}, 32'h0);
        checkOutput("to_readdata", ReadData_out, 32'h0);
        checkOutput("to_req", {31'b0, dmem_req}, 32'h0);
        applyStimulus(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        checkOutput("to_err_sticky", {31'b0, mem_error}, 32'h1);
        checkOutput("to_idle", {31'b0, stall}, 32'h0);
        #2 reset = 1'b0;
        #1 checkOutput("to_err_cleared", {31'b0, mem_error}, 32'h0);
        @(posedge clk);
        reset = 1'b1;
`else
        repeat (20) tick();
        checkOutput("nto_stall", {31'b0, stall}, 32'h1);
        checkOutput("nto_req", {31'b0, dmem_req}, 32'h1);
        checkOutput("nto_err", {31'b0, mem_error}, 32'h0);
        dmem_ack = 1'b1; dmem_rdata = 32'h0000_1111;
        tick();
        dmem_ack = 1'b0;
        checkOutput("nto_readdata", ReadData_out, 32'h0000_1111);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
